// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath sizing and the multicycle adder FSM encoding.
package cpu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    MRA_IDLE = 2'd0,
    MRA_BUSY = 2'd1,
    MRA_DONE = 2'd2
  } mra_state_e;

  // Counter width that stays legal (>= 1 bit) even for a single chunk.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple-carry adder; exposes the carry into the MSB for overflow detection.
module chunk_ripple_adder
  import cpu_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] in0,
  input  logic [CHUNK-1:0] in1,
  output logic [CHUNK-1:0] out,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign out[i]   = in0[i] ^ in1[i] ^ c[i];
    assign c[i + 1] = (in0[i] & in1[i]) | (c[i] & (in0[i] ^ in1[i]));
  end

  assign cout    = c[CHUNK];
  assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/multicycle_ripple_adder.sv
// Adder/subtractor that sums CHUNK bits per cycle, LSB chunk first, over WIDTH/CHUNK BUSY cycles.
module multicycle_ripple_adder
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_width(NCHUNK);

  // Handshake: start is taken on any edge where the FSM is IDLE or DONE (never while BUSY);
  // busy is high for the NCHUNK operating cycles, then done pulses for one cycle with results valid.
  mra_state_e state, state_n;

  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_next;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout, chunk_msb_cin;
  logic             accept, last;

  assign accept = start && (state != MRA_BUSY);
  assign last   = (state == MRA_BUSY) && (cnt == CNT_W'(NCHUNK - 1));
  assign busy   = (state == MRA_BUSY);
  assign done   = (state == MRA_DONE);

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
    .cin     (carry_q),
    .in0     (a_q[CHUNK-1:0]),
    .in1     (b_q[CHUNK-1:0]),
    .out     (chunk_sum),
    .cout    (chunk_cout),
    .msb_cin (chunk_msb_cin)
  );

  // Operands shift down one chunk per cycle; sums enter at the top, so after NCHUNK steps
  // chunk 0 has arrived at the LSB end.
  assign sum_next = WIDTH'({chunk_sum, sum_q} >> CHUNK);

  always_comb begin
    state_n = state;
    case (state)
      MRA_IDLE: if (start) state_n = MRA_BUSY;
      MRA_BUSY: if (last) state_n = MRA_DONE;
      MRA_DONE: state_n = start ? MRA_BUSY : MRA_IDLE;
      default:  state_n = MRA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MRA_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      out     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b1;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q     <= in0;
        b_q     <= sub ? ~in1 : in1;
        carry_q <= sub ? ~cin : cin;
        cnt     <= '0;
      end else if (state == MRA_BUSY) begin
        a_q     <= a_q >> CHUNK;
        b_q     <= b_q >> CHUNK;
        sum_q   <= sum_next;
        carry_q <= chunk_cout;
        cnt     <= cnt + 1'b1;
        if (last) begin
          out  <= sum_next;
          cout <= chunk_cout;
          ovf  <= chunk_msb_cin ^ chunk_cout;
          zero <= (sum_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ripple_adder.sv
// Scoreboard bench: a 32/8 instance for directed, streaming and abort cases, an 8/8 instance for single-chunk sweeps.
module tb_multicycle_ripple_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start32, sub32, cin32;
  logic [31:0] a32, b32;
  logic        busy32, done32, cout32, ovf32, zero32;
  logic [31:0] out32;

  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  out8;

  int n_cmp = 0;
  int n_bad = 0;

  logic [34:0] exp32_q[$];  // {out, cout, ovf, zero}
  logic [10:0] exp8_q[$];
  logic [31:0] hold_out;

  multicycle_ripple_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub32), .cin(cin32),
    .in0(a32), .in1(b32), .busy(busy32), .done(done32), .out(out32),
    .cout(cout32), .ovf(ovf32), .zero(zero32)
  );

  multicycle_ripple_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
    .in0(a8), .in1(b8), .busy(busy8), .done(done8), .out(out8),
    .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [34:0] model32(input logic s, input logic c,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    logic        v;
    if (s) begin
      r = {1'b0, a} - {1'b0, b} - {32'd0, c};
      r[32] = ({1'b0, a} >= ({1'b0, b} + {32'd0, c}));
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {32'd0, c};
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end
    return {r[31:0], r[32], v, r[31:0] == 32'd0};
  endfunction

  function automatic logic [10:0] model8(input logic s, input logic c,
                                         input logic [7:0] a, input logic [7:0] b);
    int          ai, bi, ri;
    logic [7:0]  r;
    logic        co, v;
    ai = int'(a);
    bi = int'(b);
    if (s) begin
      ri = ai - bi - int'(c);
      co = (ri >= 0);
      r  = 8'(ri + 256);
      v  = (a[7] != b[7]) && (r[7] != a[7]);
    end else begin
      ri = ai + bi + int'(c);
      co = (ri > 255);
      r  = 8'(ri);
      v  = (a[7] == b[7]) && (r[7] != a[7]);
    end
    return {r, co, v, r == 8'd0};
  endfunction

  // Monitors: pop and compare whenever the DUT presents done.
  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (exp32_q.size() == 0) begin
        chk("unexpected_done32", 1, 0);
      end else begin
        logic [34:0] e;
        e = exp32_q.pop_front();
        chk("result32", {out32, cout32, ovf32, zero32}, e);
        hold_out = e[34:3];
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        logic [10:0] e;
        e = exp8_q.pop_front();
        chk("result8", {out8, cout8, ovf8, zero8}, e);
      end
    end
  end

  // One 32-bit operation; inputs and start are scrambled during BUSY to show they are ignored.
  task automatic op32(input string name, input logic s, input logic c,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eo, input logic ec, input logic ev);
    int busy_cyc;
    logic seen;
    @(negedge clk);
    start32 = 1'b1; sub32 = s; cin32 = c; a32 = a; b32 = b;
    exp32_q.push_back({eo, ec, ev, eo == 32'd0});
    @(negedge clk);
    busy_cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (done32) begin
        seen = 1'b1;
        break;
      end
      if (busy32) busy_cyc++;
      chk({name, "_hold"}, out32, hold_out);
      start32 = 1'($urandom_range(0, 1));
      sub32   = 1'($urandom_range(0, 1));
      cin32   = 1'($urandom_range(0, 1));
      a32     = $urandom;
      b32     = $urandom;
      @(negedge clk);
    end
    start32 = 1'b0;
    chk({name, "_done_seen"}, seen, 1);
    chk({name, "_busy_cycles"}, busy_cyc, 4);
  endtask

  task automatic wait_done32(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done32) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, seen, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [6];
    vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};
    rst = 1'b1;
    start32 = 1'b0; sub32 = 1'b0; cin32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    hold_out = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset32", {busy32, done32, out32, cout32, ovf32, zero32}, {2'b00, 32'd0, 3'b001});
    chk("reset8", {busy8, done8, out8, cout8, ovf8, zero8}, {2'b00, 8'd0, 3'b001});
    rst = 1'b0;

    op32("add_wrap",   0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0);
    op32("add_ovf",    0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1);
    op32("sub_ovf",    1, 0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1);
    op32("sub_bin",    1, 1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 1, 0);
    op32("sub_neg",    1, 0, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 0, 0);
    op32("add_cin",    0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3569, 0, 0);
    op32("add_negovf", 0, 0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1);
    op32("sub_zero",   1, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    op32("add_chunk",  0, 0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 0, 0);
    op32("add_ripple", 0, 1, 32'h00FF_FFFF, 32'h0000_0000, 32'h0100_0000, 0, 0);

    // start held high, new operands every cycle: only accept-edge operands count.
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j > 0) chk("stream_done", done32, ((j - 1) % 5) == 4);
      start32 = 1'b1;
      sub32   = 1'(j);
      cin32   = 1'(j >> 1);
      a32     = $urandom | 32'h0000_0100;
      b32     = $urandom;
      if (j % 5 == 0) exp32_q.push_back(model32(sub32, cin32, a32, b32));
    end
    @(negedge clk);
    start32 = 1'b0;
    wait_done32("stream_last");

    // Reset two cycles into BUSY aborts the operation.
    @(negedge clk);
    start32 = 1'b1; sub32 = 1'b0; cin32 = 1'b0; a32 = 32'h0000_1234; b32 = 32'h0000_0001;
    @(negedge clk);
    start32 = 1'b0;
    chk("abort_busy", busy32, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {busy32, done32, out32, cout32, ovf32, zero32}, {2'b00, 32'd0, 3'b001});
    hold_out = 32'd0;
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_done", done32, 0);
    end
    op32("post_abort", 0, 0, 32'h0000_1234, 32'h0000_0001, 32'h0000_1235, 0, 0);

    // Single-chunk instance: one busy cycle then done.
    for (int ia = 0; ia < 6; ia++)
      for (int ib = 0; ib < 6; ib++)
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          start8 = 1'b1;
          sub8 = 1'(k >> 1);
          cin8 = 1'(k);
          a8 = vals[ia];
          b8 = vals[ib];
          exp8_q.push_back(model8(sub8, cin8, a8, b8));
          @(negedge clk);
          start8 = 1'b0;
          chk("b8_busy", {busy8, done8}, 2'b10);
          @(negedge clk);
          chk("b8_done", {busy8, done8}, 2'b01);
        end

    repeat (4) @(negedge clk);
    chk("queue32_drained", exp32_q.size(), 0);
    chk("queue8_drained", exp8_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
